// File: rtl/game_pkg.sv
// Shared game-logic constants: button channel indices and the per-channel
// auto-repeat state encoding.
package game_pkg;

  localparam int N_BTN       = 5;

  localparam int BTN_RESPAWN = 0;
  localparam int BTN_DOWN    = 1;
  localparam int BTN_LEFT    = 2;
  localparam int BTN_RIGHT   = 3;
  localparam int BTN_UP      = 4;

  typedef enum logic [1:0] {
    REP_IDLE   = 2'd0,
    REP_DELAY  = 2'd1,
    REP_REPEAT = 2'd2
  } rep_state_t;

endpackage

// File: rtl/btn_cond_if.sv
// Button bundle between the board pins and the movement stage: raw pins in,
// conditioned level and pulse vectors out.
interface btn_cond_if #(
  parameter int N_BTN = game_pkg::N_BTN
);

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_repeat;

  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, btn_repeat
  );

  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, btn_repeat
  );

endinterface

// File: rtl/btn_chan.sv
// One button channel: two-flop synchroniser, stability-count debouncer and an
// auto-repeat FSM driven by the debounced press/release events.
module btn_chan
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = 1_000_000,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYC);
  localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W = $clog2(RMAX + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

  logic              sync1_r;
  logic              sync2_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_s;
  logic              level_s;
  logic              press_evt_s;
  logic              release_evt_s;
  rep_state_t        state_r;
  rep_state_t        state_s;
  logic [RCNT_W-1:0] rcnt_r;
  logic [RCNT_W-1:0] rcnt_s;
  logic              repeat_s;

  // Debounce: the level flips only after the synchronised input has differed for DEBOUNCE_CYC edges
  always_comb begin
    cnt_s         = cnt_r;
    level_s       = btn_level;
    press_evt_s   = 1'b0;
    release_evt_s = 1'b0;
    if (sync2_r == btn_level) begin
      cnt_s = {CNT_W{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      cnt_s         = {CNT_W{1'b0}};
      level_s       = sync2_r;
      press_evt_s   = sync2_r;
      release_evt_s = ~sync2_r;
    end else begin
      cnt_s = cnt_r + CNT_W'(1);
    end
  end

  // Repeat FSM next state; a release beats a repeat that falls due in the same cycle
  always_comb begin
    state_s  = state_r;
    rcnt_s   = rcnt_r;
    repeat_s = 1'b0;
    case (state_r)
      REP_IDLE: begin
        rcnt_s = {RCNT_W{1'b0}};
        if (press_evt_s) begin
          repeat_s = 1'b1;
          state_s  = REP_DELAY;
        end else begin
          state_s  = REP_IDLE;
        end
      end
      REP_DELAY: begin
        if (release_evt_s) begin
          rcnt_s  = {RCNT_W{1'b0}};
          state_s = REP_IDLE;
        end else if (rcnt_r == DELAY_LAST) begin
          repeat_s = 1'b1;
          rcnt_s   = {RCNT_W{1'b0}};
          state_s  = REP_REPEAT;
        end else begin
          rcnt_s = rcnt_r + RCNT_W'(1);
        end
      end
      REP_REPEAT: begin
        if (release_evt_s) begin
          rcnt_s  = {RCNT_W{1'b0}};
          state_s = REP_IDLE;
        end else if (rcnt_r == PERIOD_LAST) begin
          repeat_s = 1'b1;
          rcnt_s   = {RCNT_W{1'b0}};
        end else begin
          rcnt_s = rcnt_r + RCNT_W'(1);
        end
      end
      default: begin
        rcnt_s  = {RCNT_W{1'b0}};
        state_s = REP_IDLE;
      end
    endcase
  end

  // All channel state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r     <= 1'b0;
      sync2_r     <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
      state_r     <= REP_IDLE;
      rcnt_r      <= {RCNT_W{1'b0}};
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_repeat  <= 1'b0;
    end else begin
      sync1_r     <= btn_raw;
      sync2_r     <= sync1_r;
      cnt_r       <= cnt_s;
      state_r     <= state_s;
      rcnt_r      <= rcnt_s;
      btn_level   <= level_s;
      btn_press   <= press_evt_s;
      btn_release <= release_evt_s;
      btn_repeat  <= repeat_s;
    end
  end

endmodule

// File: rtl/btn_cond.sv
// Button input conditioner: N_BTN independent synchronise/debounce/auto-repeat
// channels feeding the movement stage.
module btn_cond #(
  parameter int N_BTN         = game_pkg::N_BTN,
  parameter int DEBOUNCE_CYC  = 1_000_000,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input logic      clk,
  input logic      rst,
  btn_cond_if.slave bus
);

  logic [N_BTN-1:0] level_s;
  logic [N_BTN-1:0] press_s;
  logic [N_BTN-1:0] release_s;
  logic [N_BTN-1:0] repeat_s;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_chan #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (bus.btn_raw[g]),
      .btn_level  (level_s[g]),
      .btn_press  (press_s[g]),
      .btn_release(release_s[g]),
      .btn_repeat (repeat_s[g])
    );
  end

  assign bus.btn_level   = level_s;
  assign bus.btn_press   = press_s;
  assign bus.btn_release = release_s;
  assign bus.btn_repeat  = repeat_s;

endmodule
